pipe_reg: RTL and testbench
===========================

PIPE_REG -- requirements
Module: pipe_reg

Interface
REQ-001 Parameter DATA_W, default 32, width of one data lane.
REQ-002 Parameter NUM_LANES, default 2, number of data lanes carried (readData, ALUOut in WB use).
REQ-003 Parameter REG_W, default 5, destination-register index width.
REQ-004 Parameter CTRL_W, default 2, control-bundle width.
REQ-005 Parameter CNT_W, default 16, performance-counter width.
REQ-006 clk  input  1  clock; all state updates on negedge clk.
REQ-007 reset  input  1  synchronous, active-high; sampled on negedge clk.
REQ-008 stall  input  1  hold all stage contents this edge.
REQ-009 flush  input  1  insert bubble this edge.
REQ-010 valid_in  input  1  upstream stage holds a real instruction.
REQ-011 data_in  input  NUM_LANES*DATA_W  lane k at bits [k*DATA_W +: DATA_W].
REQ-012 reg_in  input  REG_W  destination register index.
REQ-013 ctrl_in  input  CTRL_W  control bundle; bit CTRL_W-1 is regWrite.
REQ-014 valid_out  output  1  stage holds a real instruction.
REQ-015 data_out  output  NUM_LANES*DATA_W  registered lanes.
REQ-016 reg_out  output  REG_W  registered destination index.
REQ-017 ctrl_out  output  CTRL_W  registered control bundle.
REQ-018 reg_write  output  1  ctrl_out[CTRL_W-1] AND valid_out, combinational.
REQ-019 retired_cnt  output  CNT_W  count of valid instructions loaded.
REQ-020 bubble_cnt  output  CNT_W  count of edges leaving a bubble in the stage.

Function
REQ-021 Per negedge clk priority SHALL be: reset > flush > stall > load.
REQ-022 Load (no reset/flush/stall): all outputs SHALL take their inputs; latency one edge.
REQ-023 Stall: valid_out, data_out, reg_out, ctrl_out SHALL hold.
REQ-024 Flush: valid_out and ctrl_out SHALL become 0; data_out, reg_out SHALL hold.
REQ-025 Flush with stall asserted SHALL behave as flush.
REQ-026 Load with valid_in=0 SHALL store ctrl_out=0 regardless of ctrl_in.
REQ-027 reg_write SHALL never be 1 while valid_out=0.
REQ-028 retired_cnt SHALL increment on each load edge with valid_in=1.
REQ-029 bubble_cnt SHALL increment on each flush edge and each load edge with valid_in=0; stall edges count nothing.
REQ-030 Both counters SHALL saturate at all-ones, never wrap.

Reset
REQ-031 Reset edge SHALL clear valid_out, data_out, reg_out, ctrl_out, retired_cnt, bubble_cnt to 0.
REQ-032 Reset asserted mid-stall or mid-flush SHALL take precedence; first edge after deassert is a normal edge.
REQ-033 No update SHALL occur between edges, including on reset transitions.

Structure
REQ-034 Shared package pipe_pkg SHALL hold default widths (DATA_W, REG_W, CTRL_W) and the regWrite bit-position constant.
REQ-035 One sub-module sat_counter (CNT_W, inc, reset) SHALL implement each saturating counter; instantiated twice.
REQ-036 Instantiation as WB stage: NUM_LANES=2, CTRL_W=2, ctrl bit0 = memToReg.

Verification
REQ-037 Reset, then load valid_in=1, data_in={0xDEADBEEF,0x12345678}, reg_in=9, ctrl_in=2'b11 -> after one edge outputs match, reg_write=1, retired_cnt=1.
REQ-038 Stall high three edges with changing inputs -> outputs unchanged, both counters unchanged.
REQ-039 Flush and stall together with valid stage -> valid_out=0, ctrl_out=0, reg_write=0, data_out held, bubble_cnt+1.
REQ-040 Load valid_in=0, ctrl_in=2'b11 -> ctrl_out=0, reg_write=0, bubble_cnt+1.
REQ-041 CNT_W=4, 20 valid loads -> retired_cnt reaches 15 and holds.
REQ-042 Reset asserted during stall with nonzero counters -> next edge all outputs 0; deassert, load -> normal capture.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared constants for the pipeline-register slice.
//   DEF_DATA_W / DEF_REG_W / DEF_CTRL_W : default lane, register-index and
//                                         control-bundle widths
//   reg_write_bit()                     : position of the regWrite flag
//                                         inside a control bundle
//   REG_WRITE_BIT / MEM_TO_REG_BIT      : flag positions for the default
//                                         (write-back) control bundle
package pipe_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_W  = 5;
  localparam int DEF_CTRL_W = 2;

  // regWrite always sits in the top bit of the control bundle, whatever its width
  function automatic int reg_write_bit(input int ctrl_w);
    return ctrl_w - 1;
  endfunction

  localparam int REG_WRITE_BIT  = reg_write_bit(DEF_CTRL_W);
  localparam int MEM_TO_REG_BIT = 0;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Counter that steps up by one on each falling clock edge with inc high and
// sticks at all-ones instead of wrapping.
//   clk   : clock, state changes on the falling edge
//   reset : synchronous active-high clear
//   inc   : count this edge
//   count : current value
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(negedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_reg.sv
// pipe_reg
// Generic pipeline stage register with stall/flush handling and two
// performance counters (instructions retired, bubbles left in the stage).
// Used as the write-back stage with two lanes (readData, ALUOut) and a
// two-bit control bundle {regWrite, memToReg}.
//   clk         : clock, all state changes on the falling edge
//   reset       : synchronous active-high clear
//   stall       : hold the stage contents
//   flush       : turn the stage into a bubble
//   valid_in    : upstream holds a real instruction
//   data_in     : NUM_LANES lanes, lane k at [k*DATA_W +: DATA_W]
//   reg_in      : destination register index
//   ctrl_in     : control bundle, top bit is regWrite
//   valid_out   : stage holds a real instruction
//   data_out    : registered lanes
//   reg_out     : registered destination index
//   ctrl_out    : registered control bundle
//   reg_write   : regWrite qualified by valid_out
//   retired_cnt : valid instructions loaded (saturating)
//   bubble_cnt  : edges that left a bubble in the stage (saturating)
module pipe_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_LANES = 2,
  parameter int REG_W     = DEF_REG_W,
  parameter int CTRL_W    = DEF_CTRL_W,
  parameter int CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall,
  input  logic                        flush,
  input  logic                        valid_in,
  input  logic [NUM_LANES*DATA_W-1:0] data_in,
  input  logic [REG_W-1:0]            reg_in,
  input  logic [CTRL_W-1:0]           ctrl_in,
  output logic                        valid_out,
  output logic [NUM_LANES*DATA_W-1:0] data_out,
  output logic [REG_W-1:0]            reg_out,
  output logic [CTRL_W-1:0]           ctrl_out,
  output logic                        reg_write,
  output logic [CNT_W-1:0]            retired_cnt,
  output logic [CNT_W-1:0]            bubble_cnt
);

  localparam int RW_BIT = reg_write_bit(CTRL_W);

  logic load;
  logic retire_inc;
  logic bubble_inc;

  // A load happens only when nothing of higher priority claims the edge
  assign load = !reset && !flush && !stall;

  // Flush wins over stall, so a flush always leaves a bubble even while stalled
  assign retire_inc = load && valid_in;
  assign bubble_inc = !reset && (flush || (load && !valid_in));

  always_ff @(negedge clk) begin
    if (reset) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      reg_out   <= '0;
      ctrl_out  <= '0;
    end else if (flush) begin
      // data and destination are left alone; only the bubble markers change
      valid_out <= 1'b0;
      ctrl_out  <= '0;
    end else if (!stall) begin
      valid_out <= valid_in;
      data_out  <= data_in;
      reg_out   <= reg_in;
      // an empty slot must never carry live control bits downstream
      ctrl_out  <= valid_in ? ctrl_in : '0;
    end
  end

  assign reg_write = ctrl_out[RW_BIT] & valid_out;

  sat_counter #(.CNT_W(CNT_W)) u_retired_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (retire_inc),
    .count (retired_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (bubble_inc),
    .count (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_reg.sv
// tb_pipe_reg
// Scoreboard bench for pipe_reg. Two instances share one stimulus stream:
// a 16-bit-counter instance and a 4-bit-counter instance (to reach
// saturation quickly). The driver updates an abstract stage model and
// pushes the expected outputs; a monitor pops and compares after each edge.
module tb_pipe_reg;

  localparam int DW = 32;
  localparam int NL = 2;
  localparam int RW = 5;
  localparam int CW = 2;

  logic              clk;
  logic              reset;
  logic              stall;
  logic              flush;
  logic              valid_in;
  logic [NL*DW-1:0]  data_in;
  logic [RW-1:0]     reg_in;
  logic [CW-1:0]     ctrl_in;

  logic              valid_a, valid_b;
  logic [NL*DW-1:0]  data_a, data_b;
  logic [RW-1:0]     reg_a, reg_b;
  logic [CW-1:0]     ctrl_a, ctrl_b;
  logic              rw_a, rw_b;
  logic [15:0]       ret_a, bub_a;
  logic [3:0]        ret_b, bub_b;

  typedef struct {
    logic             valid;
    logic [NL*DW-1:0] data;
    logic [RW-1:0]    rg;
    logic [CW-1:0]    ctrl;
    logic             rw;
    int               ret16;
    int               bub16;
    int               ret4;
    int               bub4;
  } exp_t;

  exp_t exp_q[$];
  exp_t model;

  int checks = 0;
  int errors = 0;

  pipe_reg #(.DATA_W(DW), .NUM_LANES(NL), .REG_W(RW), .CTRL_W(CW), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
    .data_in(data_in), .reg_in(reg_in), .ctrl_in(ctrl_in),
    .valid_out(valid_a), .data_out(data_a), .reg_out(reg_a), .ctrl_out(ctrl_a),
    .reg_write(rw_a), .retired_cnt(ret_a), .bubble_cnt(bub_a)
  );

  pipe_reg #(.DATA_W(DW), .NUM_LANES(NL), .REG_W(RW), .CTRL_W(CW), .CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
    .data_in(data_in), .reg_in(reg_in), .ctrl_in(ctrl_in),
    .valid_out(valid_b), .data_out(data_b), .reg_out(reg_b), .ctrl_out(ctrl_b),
    .reg_write(rw_b), .retired_cnt(ret_b), .bubble_cnt(bub_b)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  function automatic int bump(input int v, input int maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  // Drive one edge's inputs and record what the stage should hold after it
  task automatic applyStimulus(input logic r, input logic s, input logic f, input logic v,
                               input logic [NL*DW-1:0] d, input logic [RW-1:0] rg,
                               input logic [CW-1:0] c);
    exp_t e;
    @(posedge clk);
    #1;
    reset = r; stall = s; flush = f; valid_in = v;
    data_in = d; reg_in = rg; ctrl_in = c;
    if (r) begin
      model.valid = 1'b0; model.data = '0; model.rg = '0; model.ctrl = '0;
      model.ret16 = 0; model.bub16 = 0; model.ret4 = 0; model.bub4 = 0;
    end else if (f) begin
      model.valid = 1'b0;
      model.ctrl  = '0;
      model.bub16 = bump(model.bub16, 65535);
      model.bub4  = bump(model.bub4, 15);
    end else if (!s) begin
      model.valid = v;
      model.data  = d;
      model.rg    = rg;
      model.ctrl  = v ? c : 2'b00;
      if (v) begin
        model.ret16 = bump(model.ret16, 65535);
        model.ret4  = bump(model.ret4, 15);
      end else begin
        model.bub16 = bump(model.bub16, 65535);
        model.bub4  = bump(model.bub4, 15);
      end
    end
    e = model;
    e.rw = model.valid && model.ctrl[1];
    exp_q.push_back(e);
  endtask

  // Monitor: the stage presents a new result after every falling edge
  always @(negedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checkOutput("valid_out",   64'(valid_a), 64'(e.valid));
      checkOutput("data_out",    data_a,       e.data);
      checkOutput("reg_out",     64'(reg_a),   64'(e.rg));
      checkOutput("ctrl_out",    64'(ctrl_a),  64'(e.ctrl));
      checkOutput("reg_write",   64'(rw_a),    64'(e.rw));
      checkOutput("retired_cnt", 64'(ret_a),   64'(e.ret16));
      checkOutput("bubble_cnt",  64'(bub_a),   64'(e.bub16));
      checkOutput("small_valid", 64'(valid_b), 64'(e.valid));
      checkOutput("small_data",  data_b,       e.data);
      checkOutput("small_ctrl",  64'(ctrl_b),  64'(e.ctrl));
      checkOutput("small_rw",    64'(rw_b),    64'(e.rw));
      checkOutput("small_ret",   64'(ret_b),   64'(e.ret4));
      checkOutput("small_bub",   64'(bub_b),   64'(e.bub4));
      if (rw_a && !valid_a) checkOutput("rw_without_valid", 64'(rw_a), 64'd0);
    end
  end

  initial begin
    logic [63:0] pat;
    int budget;
    reset = 1'b1; stall = 1'b0; flush = 1'b0; valid_in = 1'b0;
    data_in = '0; reg_in = '0; ctrl_in = '0;
    model = '{valid: 1'b0, data: '0, rg: '0, ctrl: '0, rw: 1'b0,
              ret16: 0, bub16: 0, ret4: 0, bub4: 0};

    $display("[TB] reset state");
    applyStimulus(1, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 2'b11);

    $display("[TB] first valid load");
    pat = {32'hDEADBEEF, 32'h12345678};
    applyStimulus(0, 0, 0, 1, pat, 5'd9, 2'b11);

    $display("[TB] three stalled edges with changing inputs");
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 1, 0, i[0], {$urandom, $urandom}, 5'($urandom), 2'($urandom));

    $display("[TB] flush together with stall");
    applyStimulus(0, 1, 1, 1, {$urandom, $urandom}, 5'd3, 2'b11);

    $display("[TB] empty load with live control bits");
    applyStimulus(0, 0, 0, 0, {$urandom, $urandom}, 5'd4, 2'b11);

    $display("[TB] twenty valid loads for saturation");
    for (int i = 0; i < 20; i++)
      applyStimulus(0, 0, 0, 1, {$urandom, $urandom}, 5'($urandom), 2'($urandom));

    $display("[TB] reset during stall, then normal capture");
    applyStimulus(0, 1, 0, 1, {$urandom, $urandom}, 5'd7, 2'b10);
    applyStimulus(1, 1, 0, 1, {$urandom, $urandom}, 5'd7, 2'b10);
    applyStimulus(0, 0, 0, 1, 64'hCAFE_F00D_0BAD_BEEF, 5'd17, 2'b10);
    applyStimulus(1, 0, 1, 1, {$urandom, $urandom}, 5'd2, 2'b11);
    applyStimulus(0, 0, 0, 1, 64'h0123_4567_89AB_CDEF, 5'd21, 2'b01);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 300; i++)
      applyStimulus(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
                    {$urandom, $urandom}, 5'($urandom), 2'($urandom));

    budget = 0;
    while (exp_q.size() > 0 && budget < 5) begin
      @(posedge clk);
      budget++;
    end
    checkOutput("scoreboard_drain", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
